cpu_oam_dma: RTL and testbench
==============================

// Module: cpu_oam_dma
// PURPOSE
// - OAM DMA requester: the producer side of the CU FSM DMA handshake (dma_bflg / dma_by).
// - Detects a CPU write to $4014 and latches the source page. It then raises an active-low
//   DMA request and waits for the CU FSM to enter its DMA0/DMA1 states.
// - During those states it drives the bus: read {page,idx} in DMA0, write $2004 in DMA1.
//   Total 256 bytes, one byte per DMA0+DMA1 pair.
// PARAMETERS
// - TRIG_ADDR     16'h4014  CPU write address that starts a transfer
// - OAMDATA_ADDR  16'h2004  PPU OAM data port written in DMA1
// PORTS
// - CU_phi2      in   1   CPU phi2 clock; all state updates on posedge
// - CU_bRST      in   1   reset, asynchronous, active-low
// - cpu_addr     in   16  CPU address bus (CPU-driven cycles)
// - cpu_wdata    in   8   CPU write data
// - cpu_we       in   1   CPU write strobe, 1 = write
// - bus_rdata    in   8   data bus read value, valid in DMA0 cycle
// - dma_st0      in   1   CU FSM cur_state == DMA0 (decoded by CU)
// - dma_st1      in   1   CU FSM cur_state == DMA1 (decoded by CU)
// - dma_bflg     out  1   DMA request to CU, active-low (feeds cu_if.dma_bflg)
// - dma_by       out  8   bytes remaining after current one (feeds cu_if.dma_by)
// - dma_bus_en   out  1   1 = DMA owns address/data/rw bus this cycle
// - dma_addr     out  16  DMA address
// - dma_wdata    out  8   DMA write data
// - dma_rw       out  1   1 = read, 0 = write
// BEHAVIOUR
// - Reset (async, CU_bRST=0), all outputs:
//   - state=IDLE, page=0, idx=0, latch=0.
//   - dma_bflg=1, dma_by=8'hFF, dma_bus_en=0, dma_addr=0, dma_wdata=0, dma_rw=1.
// - State machine:
//   - IDLE -> PEND: on posedge with cpu_we & cpu_addr==TRIG_ADDR; page<=cpu_wdata, idx<=0.
//   - PEND: dma_bflg=0 (registered). Goes to XFER on the first posedge with dma_st0=1,
//     which also performs byte 0's read.
//   - XFER:
//     - posedge with dma_st0: latch<=bus_rdata.
//     - posedge with dma_st1: idx<=idx+1.
//     - posedge with dma_st1 & idx==8'hFF: go to IDLE and set dma_bflg<=1 on that same edge,
//       because the CU FSM leaves DMA1 on that edge.
// - dma_by = 8'hFF - idx (combinational). It reads 0 exactly during byte 255's DMA1 cycle,
//   which is the CU exit condition.
// - Bus drive is combinational. It applies in PEND or XFER only:
//   - dma_st0: bus_en=1, addr={page,idx}, rw=1.
//   - dma_st1: bus_en=1, addr=OAMDATA_ADDR, rw=0, wdata=latch.
//   - otherwise bus_en=0, rw=1.
// - Latency:
//   - Request is asserted 1 cycle after the trigger write.
//   - Transfer is 512 DMA cycles plus the CU wait to reach ST2_07.
// - Boundary and error cases:
//   - $4014 write while PEND/XFER: ignored, page unchanged. The CPU is stalled anyway; the rule
//     covers stray writes.
//   - dma_st1 while PEND, before any DMA0: protocol error. No state change; the bench flags it.
//   - dma_st0 & dma_st1 both high: protocol error. No state change, bus_en=0; bench assertion.
//   - dma_st0/dma_st1 in IDLE: ignored, bus_en=0.
//   - idx wraps 8'hFF->8'h00 only on the terminal edge, so the page never increments.
//   - Reset mid-transfer: immediate IDLE, bus released, request withdrawn. No resume.
//   - Trigger on the same edge that completes a transfer: cannot occur (the bus is DMA-owned);
//     if forced, completion has priority.
// STRUCTURE
// - Shared package nes_cpu_pkg holds:
//   - dma_state_t {DMA_IDLE, DMA_PEND, DMA_XFER}
//   - constants OAM_TRIG_ADDR and OAMDATA_ADDR
//   - the DMA0/DMA1 state codes the CU decodes into dma_st0/dma_st1
// - Single module, no sub-module: FSM, 8-bit idx counter, page/latch registers,
//   combinational bus mux.
// TESTING
// - Reset: with CU_bRST=0, all outputs are at reset values. Releasing reset with no trigger
//   leaves dma_bflg=1.
// - Write 8'h02 to $4014: dma_bflg=0 next edge. The CU model holds PEND 3 cycles, then
//   alternates st0/st1.
//   - Check addr sequence 0200,2004,0201,2004,...,02FF,2004.
//   - Check wdata equals the prior bus_rdata.
// - Terminal byte: in byte 255's DMA1, dma_by=0. On that edge dma_bflg=1, state=IDLE,
//   and dma_bus_en=0 on the next cycle.
// - Page 8'hFF: last read addr=16'hFFFF, no carry into the page, completion clean.
// - Assert CU_bRST at byte 100 (DMA1): outputs reset asynchronously. A new $4014 write of 8'h03
//   restarts from 16'h0300 with dma_by=8'hFF.
// - Protocol errors:
//   - A second $4014 write during XFER does not change page.
//   - st0&st1 together: no state/idx change, bus_en=0.

Source files
------------

// File: rtl/nes_cpu_pkg.sv
// Shared CPU-side types and constants for the CU FSM and its DMA requester.
// Latency: none (declarations only).
// Backpressure: none.
package nes_cpu_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_PEND = 2'd1,
        DMA_XFER = 2'd2
    } dma_state_t;

    localparam logic [15:0] OAM_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR  = 16'h2004;

    // CU FSM state codes that the CU decodes into dma_st0 / dma_st1.
    localparam logic [4:0] CU_ST_DMA0 = 5'h18;
    localparam logic [4:0] CU_ST_DMA1 = 5'h19;

    function automatic logic is_dma_state(input logic [4:0] st);
        return (st == CU_ST_DMA0) || (st == CU_ST_DMA1);
    endfunction

endpackage

// File: rtl/cpu_oam_dma.sv
// OAM DMA requester: latches the $4014 page, requests the CU, drives 256 read/write pairs.
// Latency: request one phi2 edge after the trigger write; 512 DMA cycles per transfer.
// Backpressure: advances only on CU-decoded DMA0/DMA1 cycles; idles otherwise.
module cpu_oam_dma #(
    parameter logic [15:0] TRIG_ADDR    = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        CU_phi2,
    input  logic        CU_bRST,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  bus_rdata,
    input  logic        dma_st0,
    input  logic        dma_st1,
    output logic        dma_bflg,
    output logic [7:0]  dma_by,
    output logic        dma_bus_en,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_rw
);
    import nes_cpu_pkg::*;

    dma_state_t  state_q;
    logic [7:0]  page_q;
    logic [7:0]  idx_q;
    logic [7:0]  idx_d;
    logic [7:0]  latch_q;
    logic        bflg_q;

    logic        trig;
    logic        rd_cyc;
    logic        wr_cyc;
    logic        active;

    assign trig   = cpu_we && (cpu_addr == TRIG_ADDR);
    // Both strobes high is a CU protocol error; treat it as neither.
    assign rd_cyc = dma_st0 && !dma_st1;
    assign wr_cyc = dma_st1 && !dma_st0;
    assign active = (state_q == DMA_PEND) || (state_q == DMA_XFER);
    assign idx_d  = idx_q + 8'd1;

    always_ff @(posedge CU_phi2 or negedge CU_bRST) begin
        if (!CU_bRST) begin
            state_q <= DMA_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            latch_q <= 8'h00;
            bflg_q  <= 1'b1;
        end else begin
            case (state_q)
                DMA_IDLE: begin
                    if (trig) begin
                        state_q <= DMA_PEND;
                        page_q  <= cpu_wdata;
                        idx_q   <= 8'h00;
                        bflg_q  <= 1'b0;
                    end
                end
                DMA_PEND: begin
                    // The first DMA0 is byte 0's read; a DMA1 here is ignored.
                    if (rd_cyc) begin
                        state_q <= DMA_XFER;
                        latch_q <= bus_rdata;
                    end
                end
                DMA_XFER: begin
                    if (rd_cyc) begin
                        latch_q <= bus_rdata;
                    end else if (wr_cyc) begin
                        idx_q <= idx_d;
                        // CU leaves DMA1 on this same edge, so drop the request now.
                        if (idx_q == 8'hFF) begin
                            state_q <= DMA_IDLE;
                            bflg_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= DMA_IDLE;
                    bflg_q  <= 1'b1;
                end
            endcase
        end
    end

    assign dma_bflg = bflg_q;
    assign dma_by   = 8'hFF - idx_q;

    always_comb begin
        dma_bus_en = 1'b0;
        dma_addr   = 16'h0000;
        dma_wdata  = 8'h00;
        dma_rw     = 1'b1;
        if (active) begin
            if (rd_cyc) begin
                dma_bus_en = 1'b1;
                dma_addr   = {page_q, idx_q};
                dma_rw     = 1'b1;
            end else if (wr_cyc) begin
                dma_bus_en = 1'b1;
                dma_addr   = OAMDATA_ADDR;
                dma_rw     = 1'b0;
                dma_wdata  = latch_q;
            end
        end
    end

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Directed bench for cpu_oam_dma with a small CU model driving dma_st0/dma_st1.
module tb_cpu_oam_dma;

    logic        CU_phi2;
    logic        CU_bRST;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  bus_rdata;
    logic        dma_st0;
    logic        dma_st1;
    logic        dma_bflg;
    logic [7:0]  dma_by;
    logic        dma_bus_en;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rw;

    int n_assert;
    int n_fail;

    cpu_oam_dma dut (
        .CU_phi2    (CU_phi2),
        .CU_bRST    (CU_bRST),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .bus_rdata  (bus_rdata),
        .dma_st0    (dma_st0),
        .dma_st1    (dma_st1),
        .dma_bflg   (dma_bflg),
        .dma_by     (dma_by),
        .dma_bus_en (dma_bus_en),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rw     (dma_rw)
    );

    initial CU_phi2 = 1'b0;
    always #5 CU_phi2 = ~CU_phi2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CU_phi2);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".bflg"},   {15'd0, dma_bflg},   16'h0001);
        chk({tag, ".by"},     {8'd0, dma_by},      16'h00FF);
        chk({tag, ".bus_en"}, {15'd0, dma_bus_en}, 16'h0000);
        chk({tag, ".addr"},   dma_addr,            16'h0000);
        chk({tag, ".wdata"},  {8'd0, dma_wdata},   16'h0000);
        chk({tag, ".rw"},     {15'd0, dma_rw},     16'h0001);
    endtask

    // Runs one full transfer from page pg. abort_at >= 0 resets during that byte's DMA1.
    // inject adds a DMA1 during PEND, a stray $4014 write and a st0&st1 cycle.
    task automatic run_xfer(input logic [7:0] pg, input int abort_at, input bit inject);
        logic [7:0] rd;
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        #1;
        chk("req_low", {15'd0, dma_bflg}, 16'h0000);
        chk("req_by", {8'd0, dma_by}, 16'h00FF);
        for (int p = 0; p < 3; p++) begin
            if (inject && p == 1) dma_st1 = 1'b1;
            #1;
            if (!(inject && p == 1)) chk("pend_bus", {15'd0, dma_bus_en}, 16'h0000);
            tick();
            dma_st1 = 1'b0;
            #1;
            chk("pend_bflg", {15'd0, dma_bflg}, 16'h0000);
            chk("pend_by", {8'd0, dma_by}, 16'h00FF);
        end
        for (int i = 0; i < 256; i++) begin
            if (inject && i == 50) begin
                dma_st0 = 1'b1; dma_st1 = 1'b1;
                #1;
                chk("both_bus_en", {15'd0, dma_bus_en}, 16'h0000);
                tick();
                dma_st0 = 1'b0; dma_st1 = 1'b0;
                #1;
                chk("both_by", {8'd0, dma_by}, 16'h00FF - 16'd50);
                chk("both_bflg", {15'd0, dma_bflg}, 16'h0000);
            end
            rd = 8'(i) ^ 8'hA5 ^ pg;
            dma_st0 = 1'b1; bus_rdata = rd;
            #1;
            chk("rd_addr", dma_addr, {pg, 8'(i)});
            chk("rd_rw", {15'd0, dma_rw}, 16'h0001);
            chk("rd_en", {15'd0, dma_bus_en}, 16'h0001);
            chk("rd_by", {8'd0, dma_by}, 16'(8'hFF - 8'(i)));
            if (inject && i == 20) begin
                cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h77;
            end
            tick();
            cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
            dma_st0 = 1'b0; dma_st1 = 1'b1; bus_rdata = 8'h00;
            #1;
            chk("wr_addr", dma_addr, 16'h2004);
            chk("wr_rw", {15'd0, dma_rw}, 16'h0000);
            chk("wr_data", {8'd0, dma_wdata}, {8'd0, rd});
            chk("wr_by", {8'd0, dma_by}, 16'(8'hFF - 8'(i)));
            if (i == abort_at) begin
                CU_bRST = 1'b0;
                #1;
                chk_reset_outputs("abort");
                dma_st1 = 1'b0;
                #1;
                CU_bRST = 1'b1;
                #1;
                chk_reset_outputs("abort_rel");
                return;
            end
            tick();
            dma_st1 = 1'b0;
            if (i < 255) chk("mid_bflg", {15'd0, dma_bflg}, 16'h0000);
        end
        #1;
        chk("done_bflg", {15'd0, dma_bflg}, 16'h0001);
        chk("done_bus_en", {15'd0, dma_bus_en}, 16'h0000);
        chk("done_by", {8'd0, dma_by}, 16'h00FF);
        dma_st0 = 1'b1;
        #1;
        chk("idle_st0_bus_en", {15'd0, dma_bus_en}, 16'h0000);
        tick();
        dma_st0 = 1'b0;
        #1;
        chk("idle_st0_bflg", {15'd0, dma_bflg}, 16'h0001);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        CU_bRST   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        bus_rdata = 8'h00;
        dma_st0   = 1'b0;
        dma_st1   = 1'b0;
        #12;
        chk_reset_outputs("rst");
        #5;
        CU_bRST = 1'b1;
        tick();
        tick();
        chk("post_rst_bflg", {15'd0, dma_bflg}, 16'h0001);
        // A write to a neighbouring address must not trigger.
        cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_wdata = 8'h02;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0000;
        #1;
        chk("no_trig_bflg", {15'd0, dma_bflg}, 16'h0001);

        run_xfer(8'h02, -1, 1'b1);
        run_xfer(8'hFF, -1, 1'b0);
        run_xfer(8'h01, 100, 1'b0);
        run_xfer(8'h03, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
